// File: rtl/button_events_pkg.sv
// Shared types and sizes for the two-button event generator.
package button_events_pkg;

   typedef enum logic [1:0] {
      EV_PRESS   = 2'b00,
      EV_RELEASE = 2'b01,
      EV_LONG    = 2'b10,
      EV_REPEAT  = 2'b11
   } ev_type_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_REPEAT
   } btn_state_t;

   localparam int EV_W       = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 8;

endpackage

// File: rtl/button_events_if.sv
// Event consumer port: head-of-FIFO event, pop strobe and sticky overflow.
interface button_events_if;
   import button_events_pkg::*;

   logic            ev_valid;
   logic [EV_W-1:0] ev_code;
   logic            ev_ack;
   logic            overflow;
   logic            ov_clr;

   modport master (output ev_valid, ev_code, overflow, input ev_ack, ov_clr);
   modport slave  (input ev_valid, ev_code, overflow, output ev_ack, ov_clr);
endinterface

// File: rtl/button_events_fsm.sv
// Per-button press/long/repeat FSM with tick counter and a one-entry pending event.
//   state     | meaning
//   ST_IDLE   | button released, waiting for press
//   ST_HELD   | pressed, counting ticks toward long-press
//   ST_REPEAT | long press reported, counting ticks between repeats
module button_fsm
   import button_events_pkg::*;
#(
   parameter int   LONG_TICKS   = 50,
   parameter int   REPEAT_TICKS = 10,
   parameter logic BUTTON_ID    = 1'b0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            tick,
   input  logic            btn_in,
   input  logic            pend_pop,
   output logic            pend_valid,
   output logic [EV_W-1:0] pend_code,
   output logic            pend_ovf
);

   localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);

   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             pend_valid_q, pend_valid_d;
   logic [EV_W-1:0]  pend_code_q, pend_code_d;
   logic             ev_fire;
   ev_type_t         ev_type;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ev_fire = 1'b0;
      ev_type = EV_PRESS;
      cnt_inc = cnt_q + 8'd1;
      case (state_q)
         ST_IDLE: begin
            if (btn_in) begin
               state_d = ST_HELD;
               cnt_d   = '0;
               ev_fire = 1'b1;
               ev_type = EV_PRESS;
            end
         end
         ST_HELD, ST_REPEAT: begin
            // release is checked first so it suppresses a coincident long/repeat
            if (!btn_in) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ev_fire = 1'b1;
               ev_type = EV_RELEASE;
            end else if (tick) begin
               if (state_q == ST_HELD && cnt_inc == LONG_C) begin
                  state_d = ST_REPEAT;
                  cnt_d   = '0;
                  ev_fire = 1'b1;
                  ev_type = EV_LONG;
               end else if (state_q == ST_REPEAT && cnt_inc == REPEAT_C) begin
                  cnt_d   = '0;
                  ev_fire = 1'b1;
                  ev_type = EV_REPEAT;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pend_valid_d = pend_valid_q & ~pend_pop;
      pend_code_d  = pend_code_q;
      pend_ovf     = ev_fire & pend_valid_q & ~pend_pop;
      if (ev_fire) begin
         pend_valid_d = 1'b1;
         pend_code_d  = {BUTTON_ID, ev_type};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_code_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_code_q  <= pend_code_d;
      end
   end

   assign pend_valid = pend_valid_q;
   assign pend_code  = pend_code_q;

endmodule

// File: rtl/button_events.sv
// Two button FSMs feeding a fixed-priority arbiter and a 4-entry event FIFO.
module button_events
   import button_events_pkg::*;
#(
   parameter int LONG_TICKS   = 50,
   parameter int REPEAT_TICKS = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick,
   input  logic              in1,
   input  logic              in2,
   button_events_if.master   ev_if
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic            p1_valid, p2_valid, p1_pop, p2_pop, p1_ovf, p2_ovf;
   logic [EV_W-1:0] p1_code, p2_code;

   button_fsm #(.LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS), .BUTTON_ID(1'b0)) u_btn1 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .btn_in(in1), .pend_pop(p1_pop),
      .pend_valid(p1_valid), .pend_code(p1_code), .pend_ovf(p1_ovf)
   );

   button_fsm #(.LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS), .BUTTON_ID(1'b1)) u_btn2 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .btn_in(in2), .pend_pop(p2_pop),
      .pend_valid(p2_valid), .pend_code(p2_code), .pend_ovf(p2_ovf)
   );

   // The arbiter always consumes the winner; if the FIFO is full it is dropped.
   assign p1_pop = p1_valid;
   assign p2_pop = p2_valid & ~p1_valid;

   logic [PTR_W:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EV_W-1:0] mem_q [FIFO_DEPTH];
   logic [EV_W-1:0] mem_d [FIFO_DEPTH];
   logic            ovf_q, ovf_d;
   logic            fifo_empty, fifo_full, push, pop, push_ok, drop;
   logic [EV_W-1:0] push_code;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop        = ev_if.ev_ack & ~fifo_empty;
   assign push       = p1_valid | p2_valid;
   assign push_code  = p1_valid ? p1_code : p2_code;
   assign push_ok    = push & (~fifo_full | pop);
   assign drop       = push & fifo_full & ~pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = push_code;
         wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ev_if.ov_clr) ovf_d = 1'b0;
      if (drop | p1_ovf | p2_ovf) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign ev_if.ev_valid = ~fifo_empty;
   assign ev_if.ev_code  = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign ev_if.overflow = ovf_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with LONG_TICKS=3, REPEAT_TICKS=2, tick every 4 clk.
module tb_button_events;

   logic clk = 1'b0;
   logic reset_n, tick, in1, in2;
   always #5 clk = ~clk;

   button_events_if bus ();

   button_events #(.LONG_TICKS(3), .REPEAT_TICKS(2)) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .in1(in1), .in2(in2), .ev_if(bus)
   );

   int total = 0;
   int bad   = 0;
   int phase = 0;

   typedef struct {
      logic       in1;
      logic       in2;
      logic       ack;
      logic       exp_v;
      logic [2:0] exp_c;
   } vec_t;

   vec_t vecs [24];

   logic [2:0] e35_code [5] = '{3'b100, 3'b110, 3'b111, 3'b111, 3'b101};
   int         e35_step [5] = '{1, 12, 20, 28, 36};
   int         seen;

   function automatic vec_t mk(logic a, logic b, logic k, logic ev, logic [2:0] ec);
      vec_t r;
      r.in1 = a; r.in2 = b; r.ack = k; r.exp_v = ev; r.exp_c = ec;
      return r;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      tick = (phase % 4 == 3) ? 1'b1 : 1'b0;
      phase++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; tick = 1'b0; in1 = 1'b0; in2 = 1'b0;
      bus.ev_ack = 1'b0; bus.ov_clr = 1'b0;

      // single press/release on in1, then simultaneous press, then ack on empty
      vecs[0]  = mk(1, 0, 0, 0, 3'b000);
      vecs[1]  = mk(1, 0, 0, 1, 3'b000);
      for (int k = 2; k < 8; k++) vecs[k] = mk(1, 0, 0, 1, 3'b000);
      vecs[8]  = mk(0, 0, 0, 1, 3'b000);
      vecs[9]  = mk(0, 0, 0, 1, 3'b000);
      vecs[10] = mk(0, 0, 1, 1, 3'b001);
      vecs[11] = mk(0, 0, 1, 0, 3'b000);
      vecs[12] = mk(1, 1, 0, 0, 3'b000);
      vecs[13] = mk(1, 1, 0, 1, 3'b000);
      vecs[14] = mk(1, 1, 0, 1, 3'b000);
      vecs[15] = mk(1, 1, 1, 1, 3'b100);
      vecs[16] = mk(1, 1, 1, 0, 3'b000);
      vecs[17] = mk(0, 0, 0, 0, 3'b000);
      vecs[18] = mk(0, 0, 0, 1, 3'b001);
      vecs[19] = mk(0, 0, 0, 1, 3'b001);
      vecs[20] = mk(0, 0, 1, 1, 3'b101);
      vecs[21] = mk(0, 0, 1, 0, 3'b000);
      vecs[22] = mk(0, 0, 1, 0, 3'b000);
      vecs[23] = mk(0, 0, 0, 0, 3'b000);

      repeat (2) @(posedge clk);
      #1;
      chk1("reset ev_valid", bus.ev_valid, 1'b0);
      chk3("reset ev_code", bus.ev_code, 3'b000);
      chk1("reset overflow", bus.overflow, 1'b0);
      reset_n = 1'b1;
      phase = 0;

      for (int k = 0; k < 24; k++) begin
         in1 = vecs[k].in1;
         in2 = vecs[k].in2;
         bus.ev_ack = vecs[k].ack;
         step();
         chk1($sformatf("vec%0d valid", k), bus.ev_valid, vecs[k].exp_v);
         if (vecs[k].exp_v) chk3($sformatf("vec%0d code", k), bus.ev_code, vecs[k].exp_c);
         chk1($sformatf("vec%0d overflow", k), bus.overflow, 1'b0);
      end
      in1 = 1'b0; in2 = 1'b0; bus.ev_ack = 1'b0;

      // in2 long hold with continuous ack; release lands on a repeat tick
      phase = 0;
      seen = 0;
      bus.ev_ack = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in2 = (i < 35) ? 1'b1 : 1'b0;
         step();
         if (bus.ev_valid) begin
            if (seen < 5) begin
               chk_int($sformatf("hold ev%0d step", seen), i, e35_step[seen]);
               chk3($sformatf("hold ev%0d code", seen), bus.ev_code, e35_code[seen]);
            end else begin
               chk_int("hold event count", seen + 1, 5);
            end
            seen++;
         end
      end
      chk_int("hold events total", seen, 5);
      chk1("hold overflow", bus.overflow, 1'b0);
      bus.ev_ack = 1'b0;

      // fill the FIFO with 000,100,001,101 then drop two more
      phase = 0;
      in1 = 1'b1; step();
      chk1("fill a0 ov", bus.overflow, 1'b0);
      in2 = 1'b1; step();
      chk1("fill a1 valid", bus.ev_valid, 1'b1);
      chk3("fill a1 code", bus.ev_code, 3'b000);
      in1 = 1'b0; step();
      in2 = 1'b0; step();
      chk1("fill a3 ov", bus.overflow, 1'b0);
      in1 = 1'b1; step();
      chk1("fill a4 ov", bus.overflow, 1'b0);
      in1 = 1'b0; step();
      chk1("fill a5 drop ov", bus.overflow, 1'b1);
      bus.ov_clr = 1'b1; step();
      chk1("clr vs set ov", bus.overflow, 1'b1);
      step();
      bus.ov_clr = 1'b0;
      chk1("ov_clr ov", bus.overflow, 1'b0);
      chk3("fill head kept", bus.ev_code, 3'b000);

      // push and pop together while full
      in2 = 1'b1; step();
      chk1("full b0 valid", bus.ev_valid, 1'b1);
      chk3("full b0 code", bus.ev_code, 3'b000);
      bus.ev_ack = 1'b1; step();
      chk1("full pushpop ov", bus.overflow, 1'b0);
      chk3("drain 1", bus.ev_code, 3'b100);
      step();
      chk3("drain 2", bus.ev_code, 3'b001);
      step();
      chk3("drain 3", bus.ev_code, 3'b101);
      step();
      chk3("drain 4", bus.ev_code, 3'b100);
      chk1("drain 4 valid", bus.ev_valid, 1'b1);
      step();
      chk1("drain empty", bus.ev_valid, 1'b0);
      bus.ev_ack = 1'b0;
      in2 = 1'b0; step(); step();
      chk1("b release valid", bus.ev_valid, 1'b1);
      chk3("b release code", bus.ev_code, 3'b101);
      bus.ev_ack = 1'b1; step();
      bus.ev_ack = 1'b0;
      chk1("b release drained", bus.ev_valid, 1'b0);
      chk1("b overflow", bus.overflow, 1'b0);

      // reset while in1 is in the repeat phase
      phase = 0;
      in1 = 1'b1;
      for (int i = 0; i < 16; i++) step();
      chk1("pre-reset valid", bus.ev_valid, 1'b1);
      chk3("pre-reset head", bus.ev_code, 3'b000);
      #3;
      reset_n = 1'b0;
      #1;
      chk1("async reset valid", bus.ev_valid, 1'b0);
      chk3("async reset code", bus.ev_code, 3'b000);
      chk1("async reset ov", bus.overflow, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk1("in reset valid", bus.ev_valid, 1'b0);
      reset_n = 1'b1;
      phase = 0;
      step();
      chk1("post-reset n", bus.ev_valid, 1'b0);
      step();
      chk1("post-reset n+1 valid", bus.ev_valid, 1'b1);
      chk3("post-reset code", bus.ev_code, 3'b000);
      bus.ev_ack = 1'b1; step();
      bus.ev_ack = 1'b0;
      chk1("post-reset popped", bus.ev_valid, 1'b0);
      step(); step();
      chk1("post-reset single", bus.ev_valid, 1'b0);
      in1 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 50: number of ticks held before a long-press event; legal range 1..255.
REQ-002 SHALL have parameter REPEAT_TICKS, default 10: number of ticks between auto-repeat events after a long press; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port tick, input, 1 bit: timebase enable pulse, one clk wide.
REQ-006 SHALL have ports in1 and in2, input, 1 bit each: debounced button levels, 1 = pressed, synchronous to clk.
REQ-007 SHALL have port ev_valid, output, 1 bit: event FIFO non-empty.
REQ-008 SHALL have port ev_code, output, 3 bits: head event; bit2 = button (0 = in1, 1 = in2); bits1:0 = type (00 press, 01 release, 10 long, 11 repeat).
REQ-009 SHALL have port ev_ack, input, 1 bit: consumer pops the head event.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag set when an event is dropped.
REQ-011 SHALL have port ov_clr, input, 1 bit: clears overflow.

Function
REQ-012 SHALL run one FSM per button with states IDLE, HELD and REPEAT.
REQ-013 IDLE->HELD when the input is 1; SHALL emit press and clear that button's tick counter.
REQ-014 In HELD, SHALL increment the counter on each tick; when the counter reaches LONG_TICKS, SHALL emit long, go to REPEAT and clear the counter.
REQ-015 In REPEAT, SHALL increment on each tick; when the counter reaches REPEAT_TICKS, SHALL emit repeat and clear the counter.
REQ-016 In HELD or REPEAT, when the input is 0, SHALL emit release and go to IDLE; when release and long/repeat coincide in one cycle, release SHALL win and the other SHALL be suppressed.
REQ-017 Each button SHALL have a 1-entry pending register loaded by its FSM event.
REQ-018 An arbiter SHALL push at most one pending event per cycle into the FIFO, with button 1 taking priority over button 2.
REQ-019 A new event arriving for a button whose pending register is still full SHALL overwrite it and set overflow.
REQ-020 The FIFO SHALL be 4 entries deep; pointers are 2 bits with an extra wrap bit; full/empty SHALL be derived from pointer compare.
REQ-021 A push into a full FIFO with no concurrent pop SHALL drop the event, set overflow and leave the FIFO unchanged.
REQ-022 A push and pop in the same cycle while full SHALL both succeed with no overflow.
REQ-023 ev_ack while ev_valid=0 SHALL be ignored.
REQ-024 ev_code SHALL be driven from the FIFO head register; its value while ev_valid=0 is don't-care.
REQ-025 Latency: with the FIFO and pending registers empty, an input change sampled at edge N SHALL load pending at edge N and push at edge N+1, making ev_valid=1 after edge N+1.
REQ-026 ov_clr SHALL clear overflow on the next edge; a simultaneous set SHALL win.

Reset
REQ-027 reset_n=0 SHALL asynchronously force: FSMs to IDLE, counters to 0, pending registers empty, FIFO pointers to 0, ev_valid=0, ev_code=0, overflow=0.
REQ-028 Reset mid-hold SHALL discard all events; a button still pressed after reset release SHALL generate a fresh press.
REQ-029 Reset deassertion need not be synchronised inside the block; the system reset generator handles it.

Structure
REQ-030 A shared package SHALL hold the event type codes (EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT), the event code width (3) and the FIFO depth (4).
REQ-031 One sub-module, button_fsm (FSM, counter and pending register), SHALL be instantiated twice.
REQ-032 The FIFO and arbiter SHALL be inline in the top level.
REQ-033 Target size: 120-400 RTL lines.

Verification
With LONG_TICKS=3, REPEAT_TICKS=2 and tick every 4 clk, the bench SHALL cover:
REQ-034 in1 pulse 0->1 held 2 ticks, then 0, no ack -> FIFO holds {000, 001}; ev_valid=1 two edges after the rise; no long.
REQ-035 in2 held 9 ticks, acking each event -> 110, 111 after 2 more ticks, 111 after 2 more ticks, then 101 at release; exact tick alignment checked.
REQ-036 in1 and in2 rising in the same cycle -> 000 pushed first, 100 one cycle later.
REQ-037 6 events generated with no ack -> FIFO full after 4; overflow=1; the first 4 codes are retained in order; ov_clr -> overflow=0.
REQ-038 Full FIFO with ev_ack and a push in the same cycle -> overflow stays 0; count stays 4.
REQ-039 reset_n pulsed low mid-REPEAT with in1=1 -> ev_valid=0 immediately; after release, a single 000 event appears.
